// File: rtl/life_pkg.sv
// Shared definitions for the streaming Game-of-Life frame stepper:
// neighbour bit positions, the FSM state type and the birth/survival rule.
package life_pkg;

  localparam int NB_NW = 0;
  localparam int NB_N  = 1;
  localparam int NB_NE = 2;
  localparam int NB_W  = 3;
  localparam int NB_E  = 4;
  localparam int NB_SW = 5;
  localparam int NB_S  = 6;
  localparam int NB_SE = 7;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DRAIN
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic next_state(input logic self_alive, input logic [7:0] n);
    logic [3:0] cnt;
    cnt = popcount8(n);
    return (cnt == 4'd3) | (self_alive & (cnt == 4'd2));
  endfunction

endpackage

// File: rtl/life_window.sv
// Two chained row-length line buffers feeding a 3x3 neighbourhood window.
// Taps are raw (unmasked) and already reflect the cell being shifted in this step.
module life_window
  import life_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       in_bit,
  output logic       self_bit,
  output logic [7:0] nb
);

  // col_live: newest window column, index 0 = top row (two rows back).
  logic [2:0] col_live;
  logic [2:0] col0_q, col0_d;
  logic [2:0] col1_q, col1_d;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lb
      logic [WIDTH-1:0] lb_q, lb_d;
      logic             lb_in;
      if (gi == 0) begin : g_head
        assign lb_in = in_bit;
      end else begin : g_chain
        assign lb_in = g_lb[gi-1].lb_q[WIDTH-1];
      end

      always_comb begin
        lb_d = lb_q;
        if (step_en) begin
          lb_d = {lb_q[WIDTH-2:0], lb_in};
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lb_q <= '0;
        end else begin
          lb_q <= lb_d;
        end
      end
    end
  endgenerate

  assign col_live = {in_bit, g_lb[0].lb_q[WIDTH-1], g_lb[1].lb_q[WIDTH-1]};

  always_comb begin
    col0_d = col0_q;
    col1_d = col1_q;
    if (step_en) begin
      col0_d = col1_q;
      col1_d = col_live;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col0_q <= '0;
      col1_q <= '0;
    end else begin
      col0_q <= col0_d;
      col1_q <= col1_d;
    end
  end

  // Window after this step's shift: left = col0_q, centre = col1_q, right = col_live.
  assign self_bit  = col1_q[1];
  assign nb[NB_NW] = col0_q[0];
  assign nb[NB_N]  = col1_q[0];
  assign nb[NB_NE] = col_live[0];
  assign nb[NB_W]  = col0_q[1];
  assign nb[NB_E]  = col_live[1];
  assign nb[NB_SW] = col0_q[2];
  assign nb[NB_S]  = col1_q[2];
  assign nb[NB_SE] = col_live[2];

endmodule

// File: rtl/life_frame_stepper.sv
// Streams one board generation in raster order and emits the next generation,
// with dead borders and a single-entry output register under valid/ready flow control.
module life_frame_stepper
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_cell,
  output logic out_valid,
  input  logic out_ready,
  output logic out_cell,
  output logic out_last,
  output logic busy
);

  localparam int N_STEPS = WIDTH * HEIGHT + WIDTH + 1;
  localparam int STEP_W  = $clog2(N_STEPS + 1);
  localparam int ROW_W   = $clog2(HEIGHT);
  localparam int COL_W   = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               out_valid_q, out_valid_d;
  logic               out_cell_q, out_cell_d;
  logic               out_last_q, out_last_d;
  logic               armed_q;

  logic       stall;
  logic       consume_state;
  logic       step_fire;
  logic       produce;
  logic       win_in;
  logic       win_self;
  logic [7:0] win_nb;
  logic [7:0] nb_mask;
  logic       next_cell;
  logic       at_last;

  assign stall         = out_valid_q & ~out_ready;
  assign consume_state = (state_q == IDLE) | (state_q == FILL) | (state_q == RUN);
  // armed_q keeps in_ready low for the first cycle after reset release.
  assign in_ready      = armed_q & consume_state & ~stall;
  assign step_fire     = consume_state ? (in_valid & in_ready)
                                       : ((state_q == FLUSH) & ~stall);
  assign produce       = step_fire & ((state_q == RUN) | (state_q == FLUSH));
  assign win_in        = (state_q == FLUSH) ? 1'b0 : in_cell;

  life_window #(
    .WIDTH(WIDTH)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_fire),
    .in_bit  (win_in),
    .self_bit(win_self),
    .nb      (win_nb)
  );

  always_comb begin
    nb_mask = 8'hFF;
    if (row_q == ROW_W'(0)) begin
      nb_mask[NB_NW] = 1'b0;
      nb_mask[NB_N]  = 1'b0;
      nb_mask[NB_NE] = 1'b0;
    end
    if (row_q == ROW_W'(HEIGHT - 1)) begin
      nb_mask[NB_SW] = 1'b0;
      nb_mask[NB_S]  = 1'b0;
      nb_mask[NB_SE] = 1'b0;
    end
    if (col_q == COL_W'(0)) begin
      nb_mask[NB_NW] = 1'b0;
      nb_mask[NB_W]  = 1'b0;
      nb_mask[NB_SW] = 1'b0;
    end
    if (col_q == COL_W'(WIDTH - 1)) begin
      nb_mask[NB_NE] = 1'b0;
      nb_mask[NB_E]  = 1'b0;
      nb_mask[NB_SE] = 1'b0;
    end
  end

  assign next_cell = next_state(win_self, win_nb & nb_mask);
  assign at_last   = (row_q == ROW_W'(HEIGHT - 1)) & (col_q == COL_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_cell_d  = out_cell_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_cell_d  = 1'b0;
      out_last_d  = 1'b0;
    end

    if (produce) begin
      out_valid_d = 1'b1;
      out_cell_d  = next_cell;
      out_last_d  = at_last;
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = at_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (step_fire) begin
      step_d = step_q + STEP_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (step_fire) state_d = FILL;
      end
      FILL: begin
        if (step_fire && step_q == STEP_W'(WIDTH)) state_d = RUN;
      end
      RUN: begin
        if (step_fire && step_q == STEP_W'(WIDTH * HEIGHT - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (step_fire && step_q == STEP_W'(N_STEPS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_cell_q  <= 1'b0;
      out_last_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_cell_q  <= out_cell_d;
      out_last_q  <= out_last_d;
      armed_q     <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cell  = out_cell_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule
